// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;

  localparam logic [15:0] ERR_FILL = 16'h0000;

  // Keeps an out-of-range LATENCY from building a counter that never terminates.
  function automatic int clamp_latency(input int lat);
    if (lat < LATENCY_MIN) return LATENCY_MIN;
    if (lat > LATENCY_MAX) return LATENCY_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one asynchronous read port, one synchronous write port, no reset.
module imem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       rdata
);

  logic [15:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction fetch responder with program-load port.
// Optional misaligned-fetch error reporting is enabled by defining IMEM_ALIGN_CHK_EN.
//
// state | meaning
// IDLE  | no request in flight, ready to accept
// WAIT  | request captured, latency counter running down
// RESP  | response presented this cycle, ready to accept the next request
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_instr,
  output logic        resp_err,
  input  logic        ld_en,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data
);

  localparam int LAT = clamp_latency(LATENCY);
  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [DEPTH_LOG2-1:0] rd_idx, ld_idx;
  logic [15:0] rd_data, fetch_data, hold_data;
  logic fetch_err, hold_err;
  logic accept;
  logic unused_addr_bits;

  assign rd_idx = req_addr[DEPTH_LOG2:1];
  assign ld_idx = ld_addr[DEPTH_LOG2:1];
  assign unused_addr_bits = ^{req_addr, ld_addr};

  imem_array #(
    .ADDR_W(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .we   (ld_en),
    .waddr(ld_idx),
    .wdata(ld_data),
    .raddr(rd_idx),
    .rdata(rd_data)
  );

`ifdef IMEM_ALIGN_CHK_EN
  assign fetch_err = req_addr[0];
`else
  assign fetch_err = 1'b0;
`endif

  assign fetch_data = fetch_err ? ERR_FILL : rd_data;

  // Ready is gated by reset directly so it is low throughout reset and high
  // in the very first cycle after release.
  assign req_ready = rst && (state != WAIT);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          cnt_nxt   = CNT_LOAD;
          state_nxt = (LAT == 1) ? RESP : WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        // terminal count: this decrement takes the counter to zero
        if (cnt == 4'd1) state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      hold_data  <= 16'h0000;
      hold_err   <= 1'b0;
      resp_valid <= 1'b0;
      resp_instr <= 16'h0000;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      resp_valid <= (state_nxt == RESP);
      if (accept) begin
        hold_data <= fetch_data;
        hold_err  <= fetch_err;
      end
      // With LATENCY 1 the word goes straight from the array to the outputs.
      if (state_nxt == RESP) begin
        resp_instr <= accept ? fetch_data : hold_data;
        resp_err   <= accept ? fetch_err  : hold_err;
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Randomized and directed bench for imem_responder against a cycle-count reference model.
module tb_imem_responder;

  localparam int DL    = 10;
  localparam int LAT   = 2;
  localparam int WORDS = 1 << DL;
`ifdef IMEM_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_instr;
  logic        resp_err;
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [15:0] ld_data;

  always #5 clk = ~clk;

  imem_responder #(
    .DEPTH_LOG2(DL),
    .LATENCY   (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_instr(resp_instr),
    .resp_err  (resp_err),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  typedef struct {
    int          due;
    logic [15:0] d;
    logic        e;
  } exp_t;

  exp_t        pend[$];
  int          resp_cycles[$];
  logic [15:0] mem_m [WORDS];
  logic [15:0] last_d;
  logic        last_e;
  int          cyc, next_ok, n_chk, n_pass;
  bit          acc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic l,
                       input logic [15:0] la, input logic [15:0] ld);
    req_valid = v;
    req_addr  = a;
    ld_en     = l;
    ld_addr   = la;
    ld_data   = ld;
  endtask

  // One clock: model reacts to the sampled inputs, then outputs are compared.
  task automatic step(output bit accepted);
    exp_t x;
    bit   vexp;
    @(posedge clk);
    cyc++;
    accepted = req_valid && (cyc >= next_ok);
    if (accepted) begin
      x.due = cyc + LAT - 1;
      x.e   = ALIGN && req_addr[0];
      x.d   = x.e ? 16'h0000 : mem_m[(req_addr >> 1) % WORDS];
      pend.push_back(x);
      next_ok = cyc + LAT;
    end
    if (ld_en) mem_m[(ld_addr >> 1) % WORDS] = ld_data;
    #1;
    vexp = (pend.size() > 0) && (pend[0].due == cyc);
    check_val("resp_valid", 32'(resp_valid), 32'(vexp));
    if (vexp) begin
      last_d = pend[0].d;
      last_e = pend[0].e;
      void'(pend.pop_front());
      resp_cycles.push_back(cyc);
    end
    check_val("resp_instr", 32'(resp_instr), 32'(last_d));
    check_val("resp_err", 32'(resp_err), 32'(last_e));
    check_val("req_ready", 32'(req_ready), 32'(cyc + 1 >= next_ok));
  endtask

  initial begin
    logic [15:0] list[3];
    int k;
    n_chk = 0; n_pass = 0; cyc = 0; next_ok = 0;
    last_d = 16'h0000; last_e = 1'b0;
    rst = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_valid", 32'(resp_valid), 32'd0);
    check_val("rst_instr", 32'(resp_instr), 32'h0);
    check_val("rst_err", 32'(resp_err), 32'd0);
    rst = 1'b1;
    #1 check_val("rel_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < WORDS; i++) begin
      drive(1'b0, 16'h0, 1'b1, 16'(i * 2), 16'($urandom));
      step(acc);
    end

    // basic fetch
    drive(1'b0, 16'h0, 1'b1, 16'h0010, 16'h1234); step(acc);
    drive(1'b1, 16'h0010, 1'b0, 16'h0, 16'h0);     step(acc);
    check_val("r032_accept", 32'(acc), 32'd1);
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);        step(acc);
    check_val("r032_valid", 32'(resp_valid), 32'd1);
    check_val("r032_instr", 32'(resp_instr), 32'h1234);
    check_val("r032_err", 32'(resp_err), 32'd0);

    // back-to-back stream
    list[0] = 16'h0000; list[1] = 16'h0002; list[2] = 16'h0004;
    resp_cycles.delete();
    k = 0;
    for (int i = 0; i < 20 && k < 3; i++) begin
      drive(1'b1, list[k], 1'b0, 16'h0, 16'h0);
      step(acc);
      if (acc) k++;
    end
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    repeat (4) step(acc);
    check_val("r033_accepts", 32'(k), 32'd3);
    check_val("r033_resps", 32'(resp_cycles.size()), 32'd3);
    if (resp_cycles.size() == 3) begin
      check_val("r033_gap1", 32'(resp_cycles[1] - resp_cycles[0]), 32'(LAT));
      check_val("r033_gap2", 32'(resp_cycles[2] - resp_cycles[1]), 32'(LAT));
    end

    // address wrap
    drive(1'b0, 16'h0, 1'b1, 16'h0000, 16'hBEEF); step(acc);
    drive(1'b1, 16'h0800, 1'b0, 16'h0, 16'h0);     step(acc);
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);        step(acc);
    check_val("r034_instr", 32'(resp_instr), 32'hBEEF);

    // odd address
    drive(1'b0, 16'h0, 1'b1, 16'h0002, 16'hA5A5); step(acc);
    drive(1'b1, 16'h0003, 1'b0, 16'h0, 16'h0);     step(acc);
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);        step(acc);
    check_val("r035_instr", 32'(resp_instr), ALIGN ? 32'h0 : 32'hA5A5);
    check_val("r035_err", 32'(resp_err), 32'(ALIGN));

    // reset while waiting
    drive(1'b1, 16'h0010, 1'b0, 16'h0, 16'h0); step(acc);
    check_val("r036_accept", 32'(acc), 32'd1);
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    #2 rst = 1'b0;
    #1;
    check_val("r036_ready", 32'(req_ready), 32'd0);
    check_val("r036_valid", 32'(resp_valid), 32'd0);
    check_val("r036_instr", 32'(resp_instr), 32'h0);
    @(posedge clk); @(posedge clk);
    #1 check_val("r036_valid_hold", 32'(resp_valid), 32'd0);
    rst = 1'b1;
    pend.delete();
    last_d = 16'h0000; last_e = 1'b0; next_ok = 0;
    #1 check_val("r036_rel_ready", 32'(req_ready), 32'd1);
    repeat (4) step(acc);

    // load colliding with accept
    drive(1'b0, 16'h0, 1'b1, 16'h0020, 16'h1111); step(acc);
    drive(1'b1, 16'h0020, 1'b1, 16'h0020, 16'h2222); step(acc);
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);          step(acc);
    check_val("r037_old", 32'(resp_instr), 32'h1111);
    drive(1'b1, 16'h0020, 1'b0, 16'h0, 16'h0);       step(acc);
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);          step(acc);
    check_val("r037_new", 32'(resp_instr), 32'h2222);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a;
      a = 16'($urandom);
      drive(($urandom_range(0, 3) != 0), a, ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) != 0) ? a : 16'($urandom), 16'($urandom));
      step(acc);
    end
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    repeat (4) step(acc);
    check_val("drained", 32'(pend.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, SHALL set storage to 2**DEPTH_LOG2 16-bit words.
REQ-002 Parameter LATENCY, default 2, legal 1..15, SHALL set request-accept-to-response delay in cycles.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low (0 = in reset).
REQ-005 req_valid  input  1  SHALL indicate a fetch read request is present.
REQ-006 req_addr  input  16  SHALL be the byte address of the requested instruction.
REQ-007 req_ready  output  1  SHALL indicate a request can be accepted this cycle.
REQ-008 resp_valid  output  1  SHALL be a one-cycle pulse marking resp_instr and resp_err valid.
REQ-009 resp_instr  output  16  SHALL be the returned instruction word.
REQ-010 resp_err  output  1  SHALL flag a faulted request.
REQ-011 ld_en  input  1  SHALL write ld_data to the word at ld_addr (program load).
REQ-012 ld_addr  input  16  SHALL be the load byte address.
REQ-013 ld_data  input  16  SHALL be the load data.

Function
REQ-014 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 in IDLE and RESP, 0 in WAIT.
REQ-015 Request SHALL be accepted on an edge where req_valid && req_ready; req_valid while not ready SHALL be ignored, not queued.
REQ-016 On accept the word SHALL be read and captured; a latency counter SHALL load LATENCY-1; next state WAIT, or RESP if LATENCY==1.
REQ-017 WAIT SHALL decrement the counter each cycle and go to RESP when it reaches 0.
REQ-018 Accept at edge N SHALL produce resp_valid high exactly in the cycle following edge N+LATENCY-1, for one cycle.
REQ-019 RESP SHALL go to IDLE if no request is accepted, else reload per REQ-016; sustained throughput SHALL be one response per LATENCY cycles.
REQ-020 Word index SHALL be addr[DEPTH_LOG2:1]; upper bits ignored, so addresses wrap modulo storage size.
REQ-021 ld_en SHALL be honoured in every state; a load to the word being accepted in the same cycle SHALL leave the response carrying the old data.
REQ-022 resp_instr and resp_err SHALL hold their last values when resp_valid is 0.
REQ-023 No back-pressure on responses: the requester SHALL consume each resp_valid pulse.

Reset
REQ-024 While rst=0: state IDLE, req_ready=0, resp_valid=0, resp_instr=16'h0000, resp_err=0, counter=0.
REQ-025 req_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-026 Reset mid-operation SHALL abandon the pending request; no response SHALL be issued for it.
REQ-027 Storage contents SHALL NOT be reset.

Configuration
REQ-028 With IMEM_ALIGN_CHK_EN defined, req_addr[0]=1 SHALL return resp_err=1 and resp_instr=16'h0000 with normal latency.
REQ-029 Without IMEM_ALIGN_CHK_EN, req_addr[0] SHALL be ignored and resp_err SHALL be constant 0.

Structure
REQ-030 Shared package SHALL hold the FSM state typedef (IDLE/WAIT/RESP), the LATENCY legal-range constants and the error-fill value 16'h0000.
REQ-031 Storage SHALL be a sub-module imem_array: one async-read port, one sync-write port, no reset.

Verification
REQ-032 Load 0x1234 at 0x0010, request 0x0010 at edge N, LATENCY=2 -> resp_valid in cycle after N+1, resp_instr=0x1234, resp_err=0.
REQ-033 req_valid held high for 0x0000, 0x0002, 0x0004 -> three responses, spaced 2 cycles, in order.
REQ-034 DEPTH_LOG2=10, load 0xBEEF at 0x0000, request 0x0800 -> resp_instr=0xBEEF (wrap).
REQ-035 Request 0x0003 -> with IMEM_ALIGN_CHK_EN: resp_err=1, resp_instr=0x0000; without: data from word 0x0002, resp_err=0.
REQ-036 Drive rst=0 in WAIT -> resp_valid stays 0, no response after release, req_ready=1 cycle after release.
REQ-037 Same-edge accept of 0x0020 (holding 0x1111) and load 0x2222 to 0x0020 -> resp_instr=0x1111; next request -> 0x2222.
